// File: rtl/cache_fm_req_q.sv
// Cache-to-far-memory request queue.
// Holds fill reads and dirty writebacks for far memory in a circular FIFO.
// Tracks which TQ entries have a fill in flight.
// Registers fill responses back to the TQ.
// Keeps sticky error flags for overflow, duplicate fills and unexpected responses.
module cache_fm_req_q #(
  parameter int FM_Q_DEPTH   = 4,
  parameter int NUM_TQ_ENTRY = 8,
  parameter int CL_ADDR_W    = 28,
  localparam int TQ_ID_W     = $clog2(NUM_TQ_ENTRY)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_valid_q3,
  input  logic [CL_ADDR_W-1:0]    miss_cl_address_q3,
  input  logic [TQ_ID_W-1:0]      miss_tq_id_q3,
  input  logic                    evict_valid_q3,
  input  logic [CL_ADDR_W-1:0]    evict_cl_address_q3,
  input  logic [127:0]            evict_cl_data_q3,
  output logic                    fm_q_almost_full,
  output logic                    cache2fm_req_valid,
  output logic                    cache2fm_req_opcode,
  output logic [CL_ADDR_W-1:0]    cache2fm_req_address,
  output logic [127:0]            cache2fm_req_data,
  output logic [TQ_ID_W-1:0]      cache2fm_req_tq_id,
  input  logic                    fm2cache_req_ready,
  input  logic                    fm_rsp_valid_in,
  input  logic [127:0]            fm_rsp_data_in,
  input  logic [TQ_ID_W-1:0]      fm_rsp_tq_id_in,
  output logic                    fm2cache_rd_rsp_valid,
  output logic [127:0]            fm2cache_rd_rsp_data,
  output logic [TQ_ID_W-1:0]      fm2cache_rd_rsp_tq_id,
  output logic [NUM_TQ_ENTRY-1:0] fill_outstanding,
  output logic                    err_overflow,
  output logic                    err_dup_fill,
  output logic                    err_bad_rsp
);

  localparam int PTR_W = $clog2(FM_Q_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FM_Q_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_X = (CNT_W + 1)'(FM_Q_DEPTH);

  // Queue storage; contents are meaningless until written, so no reset.
  logic                 op_mem   [FM_Q_DEPTH];
  logic [CL_ADDR_W-1:0] addr_mem [FM_Q_DEPTH];
  logic [127:0]         data_mem [FM_Q_DEPTH];
  logic [TQ_ID_W-1:0]   tq_mem   [FM_Q_DEPTH];

  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]        count_r;
  logic [NUM_TQ_ENTRY-1:0] fill_outstanding_r;
  logic                    err_overflow_r, err_dup_fill_r, err_bad_rsp_r;
  logic                    rsp_valid_r;
  logic [127:0]            rsp_data_r;
  logic [TQ_ID_W-1:0]      rsp_tq_id_r;

  logic                    pop_s, ovf_s, do_wb_s, do_fill_s, rsp_good_s, dup_s;
  logic [CNT_W:0]          next_occ_s;
  logic [CNT_W-1:0]        n_acc_s;
  logic [PTR_W-1:0]        fill_ptr_s;
  logic [NUM_TQ_ENTRY-1:0] fo_nxt_s;

  // Push/pop arbitration: both pushes of a dual push are accepted or both are dropped.
  always_comb begin
    pop_s      = (count_r != {CNT_W{1'b0}}) && fm2cache_req_ready;
    next_occ_s = {1'b0, count_r} - {{CNT_W{1'b0}}, pop_s}
               + {{CNT_W{1'b0}}, evict_valid_q3} + {{CNT_W{1'b0}}, miss_valid_q3};
    ovf_s      = (evict_valid_q3 || miss_valid_q3) && (next_occ_s > DEPTH_X);
    do_wb_s    = evict_valid_q3 && !ovf_s;
    do_fill_s  = miss_valid_q3 && !ovf_s;
    n_acc_s    = CNT_W'({1'b0, do_wb_s} + {1'b0, do_fill_s});
    if (evict_valid_q3) begin
      fill_ptr_s = wr_ptr_r + PTR_W'(1);
    end else begin
      fill_ptr_s = wr_ptr_r;
    end
  end

  // Fill tracking: a response clears its bit, and a new fill on the same id overrides the clear.
  always_comb begin
    rsp_good_s = fm_rsp_valid_in && fill_outstanding_r[fm_rsp_tq_id_in];
    fo_nxt_s   = fill_outstanding_r;
    if (rsp_good_s) begin
      fo_nxt_s[fm_rsp_tq_id_in] = 1'b0;
    end else begin
      fo_nxt_s = fill_outstanding_r;
    end
    if (do_fill_s) begin
      fo_nxt_s[miss_tq_id_q3] = 1'b1;
    end else begin
      fo_nxt_s = fo_nxt_s;
    end
    // A fill whose previous instance completes this very cycle is not a duplicate.
    dup_s = do_fill_s && fill_outstanding_r[miss_tq_id_q3]
          && !(rsp_good_s && (fm_rsp_tq_id_in == miss_tq_id_q3));
  end

  // Write accepted entries; the writeback goes in ahead of the fill.
  always_ff @(posedge clk) begin
    if (do_wb_s) begin
      op_mem[wr_ptr_r]   <= 1'b1;
      addr_mem[wr_ptr_r] <= evict_cl_address_q3;
      data_mem[wr_ptr_r] <= evict_cl_data_q3;
      tq_mem[wr_ptr_r]   <= {TQ_ID_W{1'b0}};
    end
    if (do_fill_s) begin
      op_mem[fill_ptr_s]   <= 1'b0;
      addr_mem[fill_ptr_s] <= miss_cl_address_q3;
      data_mem[fill_ptr_s] <= 128'd0;
      tq_mem[fill_ptr_s]   <= miss_tq_id_q3;
    end
  end

  // Control state: pointers, occupancy, fill tracking, response register and sticky errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r           <= {PTR_W{1'b0}};
      rd_ptr_r           <= {PTR_W{1'b0}};
      count_r            <= {CNT_W{1'b0}};
      fill_outstanding_r <= {NUM_TQ_ENTRY{1'b0}};
      err_overflow_r     <= 1'b0;
      err_dup_fill_r     <= 1'b0;
      err_bad_rsp_r      <= 1'b0;
      rsp_valid_r        <= 1'b0;
      rsp_data_r         <= 128'd0;
      rsp_tq_id_r        <= {TQ_ID_W{1'b0}};
    end else begin
      wr_ptr_r           <= wr_ptr_r + PTR_W'(n_acc_s);
      rd_ptr_r           <= rd_ptr_r + PTR_W'(pop_s);
      count_r            <= count_r + n_acc_s - CNT_W'(pop_s);
      fill_outstanding_r <= fo_nxt_s;
      err_overflow_r     <= err_overflow_r | ovf_s;
      err_dup_fill_r     <= err_dup_fill_r | dup_s;
      err_bad_rsp_r      <= err_bad_rsp_r | (fm_rsp_valid_in && !rsp_good_s);
      rsp_valid_r        <= rsp_good_s;
      if (rsp_good_s) begin
        rsp_data_r  <= fm_rsp_data_in;
        rsp_tq_id_r <= fm_rsp_tq_id_in;
      end else begin
        rsp_data_r  <= rsp_data_r;
        rsp_tq_id_r <= rsp_tq_id_r;
      end
    end
  end

  // Head fields come straight from storage and read as zero when the queue is empty.
  always_comb begin
    cache2fm_req_valid = (count_r != {CNT_W{1'b0}});
    if (cache2fm_req_valid) begin
      cache2fm_req_opcode  = op_mem[rd_ptr_r];
      cache2fm_req_address = addr_mem[rd_ptr_r];
      cache2fm_req_data    = data_mem[rd_ptr_r];
      cache2fm_req_tq_id   = tq_mem[rd_ptr_r];
    end else begin
      cache2fm_req_opcode  = 1'b0;
      cache2fm_req_address = {CL_ADDR_W{1'b0}};
      cache2fm_req_data    = 128'd0;
      cache2fm_req_tq_id   = {TQ_ID_W{1'b0}};
    end
  end

  assign fm_q_almost_full      = (DEPTH_C - count_r) < CNT_W'(2);
  assign fm2cache_rd_rsp_valid = rsp_valid_r;
  assign fm2cache_rd_rsp_data  = rsp_data_r;
  assign fm2cache_rd_rsp_tq_id = rsp_tq_id_r;
  assign fill_outstanding      = fill_outstanding_r;
  assign err_overflow          = err_overflow_r;
  assign err_dup_fill          = err_dup_fill_r;
  assign err_bad_rsp           = err_bad_rsp_r;

endmodule

// File: tb/tb_cache_fm_req_q.sv
// Self-checking bench for cache_fm_req_q.
// Directed scenarios come first, followed by randomized traffic.
// All traffic is checked against a queue-level reference model.
module tb_cache_fm_req_q;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid_q3, evict_valid_q3, fm2cache_req_ready, fm_rsp_valid_in;
  logic [27:0]  miss_cl_address_q3, evict_cl_address_q3;
  logic [2:0]   miss_tq_id_q3, fm_rsp_tq_id_in;
  logic [127:0] evict_cl_data_q3, fm_rsp_data_in;
  logic         fm_q_almost_full, cache2fm_req_valid, cache2fm_req_opcode;
  logic [27:0]  cache2fm_req_address;
  logic [127:0] cache2fm_req_data, fm2cache_rd_rsp_data;
  logic [2:0]   cache2fm_req_tq_id, fm2cache_rd_rsp_tq_id;
  logic         fm2cache_rd_rsp_valid, err_overflow, err_dup_fill, err_bad_rsp;
  logic [7:0]   fill_outstanding;

  cache_fm_req_q dut (
    .clk(clk), .rst(rst),
    .miss_valid_q3(miss_valid_q3), .miss_cl_address_q3(miss_cl_address_q3),
    .miss_tq_id_q3(miss_tq_id_q3), .evict_valid_q3(evict_valid_q3),
    .evict_cl_address_q3(evict_cl_address_q3), .evict_cl_data_q3(evict_cl_data_q3),
    .fm_q_almost_full(fm_q_almost_full), .cache2fm_req_valid(cache2fm_req_valid),
    .cache2fm_req_opcode(cache2fm_req_opcode), .cache2fm_req_address(cache2fm_req_address),
    .cache2fm_req_data(cache2fm_req_data), .cache2fm_req_tq_id(cache2fm_req_tq_id),
    .fm2cache_req_ready(fm2cache_req_ready), .fm_rsp_valid_in(fm_rsp_valid_in),
    .fm_rsp_data_in(fm_rsp_data_in), .fm_rsp_tq_id_in(fm_rsp_tq_id_in),
    .fm2cache_rd_rsp_valid(fm2cache_rd_rsp_valid), .fm2cache_rd_rsp_data(fm2cache_rd_rsp_data),
    .fm2cache_rd_rsp_tq_id(fm2cache_rd_rsp_tq_id), .fill_outstanding(fill_outstanding),
    .err_overflow(err_overflow), .err_dup_fill(err_dup_fill), .err_bad_rsp(err_bad_rsp)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct packed {
    logic         op;
    logic [27:0]  addr;
    logic [127:0] data;
    logic [2:0]   tq;
  } ent_t;

  ent_t         q[$];
  logic [7:0]   m_fo;
  logic         m_ovf, m_dup, m_bad, m_rv;
  logic [127:0] m_rdata;
  logic [2:0]   m_rtq;
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one clock edge, using the queue contents before the edge.
  task automatic model_edge();
    int  occ;
    bit  pop, good, ovf;
    logic [7:0] fo_old;
    ent_t e;
    if (rst) begin
      q.delete();
      m_fo = 8'h00; m_ovf = 1'b0; m_dup = 1'b0; m_bad = 1'b0;
      m_rv = 1'b0; m_rdata = 128'd0; m_rtq = 3'd0;
      return;
    end
    fo_old = m_fo;
    pop  = (q.size() != 0) && fm2cache_req_ready;
    occ  = q.size() - int'(pop) + int'(evict_valid_q3) + int'(miss_valid_q3);
    ovf  = (evict_valid_q3 || miss_valid_q3) && (occ > DEPTH);
    good = fm_rsp_valid_in && fo_old[fm_rsp_tq_id_in];
    if (pop) void'(q.pop_front());
    if (ovf) m_ovf = 1'b1;
    if (fm_rsp_valid_in && !good) m_bad = 1'b1;
    m_rv = good;
    if (good) begin
      m_rdata = fm_rsp_data_in;
      m_rtq   = fm_rsp_tq_id_in;
      m_fo[fm_rsp_tq_id_in] = 1'b0;
    end
    if (!ovf && evict_valid_q3) begin
      e = '{op: 1'b1, addr: evict_cl_address_q3, data: evict_cl_data_q3, tq: 3'd0};
      q.push_back(e);
    end
    if (!ovf && miss_valid_q3) begin
      e = '{op: 1'b0, addr: miss_cl_address_q3, data: 128'd0, tq: miss_tq_id_q3};
      q.push_back(e);
      if (fo_old[miss_tq_id_q3] && !(good && fm_rsp_tq_id_in == miss_tq_id_q3)) m_dup = 1'b1;
      m_fo[miss_tq_id_q3] = 1'b1;
    end
  endtask

  task automatic check_all();
    ent_t h;
    h = (q.size() != 0) ? q[0] : '0;
    chk("req_valid", 128'(cache2fm_req_valid), 128'(q.size() != 0));
    chk("req_opcode", 128'(cache2fm_req_opcode), 128'(h.op));
    chk("req_address", 128'(cache2fm_req_address), 128'(h.addr));
    chk("req_data", cache2fm_req_data, h.data);
    chk("req_tq_id", 128'(cache2fm_req_tq_id), 128'(h.tq));
    chk("almost_full", 128'(fm_q_almost_full), 128'((DEPTH - q.size()) < 2));
    chk("fill_outstanding", 128'(fill_outstanding), 128'(m_fo));
    chk("err_overflow", 128'(err_overflow), 128'(m_ovf));
    chk("err_dup_fill", 128'(err_dup_fill), 128'(m_dup));
    chk("err_bad_rsp", 128'(err_bad_rsp), 128'(m_bad));
    chk("rd_rsp_valid", 128'(fm2cache_rd_rsp_valid), 128'(m_rv));
    chk("rd_rsp_data", fm2cache_rd_rsp_data, m_rdata);
    chk("rd_rsp_tq_id", 128'(fm2cache_rd_rsp_tq_id), 128'(m_rtq));
  endtask

  task automatic idle();
    rst = 1'b0; miss_valid_q3 = 1'b0; evict_valid_q3 = 1'b0; fm_rsp_valid_in = 1'b0;
    miss_cl_address_q3 = 28'd0; miss_tq_id_q3 = 3'd0; evict_cl_address_q3 = 28'd0;
    evict_cl_data_q3 = 128'd0; fm_rsp_data_in = 128'd0; fm_rsp_tq_id_in = 3'd0;
  endtask

  // Advance one clock with the currently driven inputs, then compare against the model.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  task automatic miss(input logic [27:0] a, input logic [2:0] t);
    miss_valid_q3 = 1'b1; miss_cl_address_q3 = a; miss_tq_id_q3 = t;
  endtask

  // Directed steps followed by randomized traffic.
  initial begin
    idle();
    fm2cache_req_ready = 1'b0;
    rst = 1'b1; step();
    rst = 1'b1; step();
    chk("reset_valid", 128'(cache2fm_req_valid), 128'd0);
    chk("reset_af", 128'(fm_q_almost_full), 128'd0);

    // Single miss, consumed right away.
    fm2cache_req_ready = 1'b1;
    miss(28'h0000123, 3'd5); step();
    chk("single_addr", 128'(cache2fm_req_address), 128'h123);
    chk("single_fo", 128'(fill_outstanding), 128'h20);
    step();
    chk("single_popped", 128'(cache2fm_req_valid), 128'd0);

    // Dual push with the consumer stalled, then fill up and overflow.
    fm2cache_req_ready = 1'b0;
    evict_valid_q3 = 1'b1; evict_cl_address_q3 = 28'h00000AA;
    evict_cl_data_q3 = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
    miss(28'h00000BB, 3'd2); step();
    chk("dual_head_wb", 128'(cache2fm_req_opcode), 128'd1);
    chk("dual_af_two_free", 128'(fm_q_almost_full), 128'd0);
    miss(28'h00000CC, 3'd3); step();
    chk("three_af", 128'(fm_q_almost_full), 128'd1);
    miss(28'h00000DD, 3'd4); step();
    miss(28'h00000EE, 3'd6); step();
    chk("ovf_flag", 128'(err_overflow), 128'd1);
    chk("ovf_head", 128'(cache2fm_req_address), 128'hAA);

    // Drain the writeback, then return fill tq 2.
    fm2cache_req_ready = 1'b1; step();
    chk("pop_head_fill", 128'(cache2fm_req_address), 128'hBB);
    fm2cache_req_ready = 1'b0;
    fm_rsp_valid_in = 1'b1; fm_rsp_tq_id_in = 3'd2;
    fm_rsp_data_in = 128'h1111_2222_3333_4444; step();
    chk("rsp_data", fm2cache_rd_rsp_data, 128'h1111_2222_3333_4444);
    chk("rsp_clear", 128'(fill_outstanding[2]), 128'd0);

    // Response for an id that has no fill outstanding.
    fm_rsp_valid_in = 1'b1; fm_rsp_tq_id_in = 3'd7; step();
    chk("bad_rsp_flag", 128'(err_bad_rsp), 128'd1);

    // Reset with queued entries and a good response in flight.
    rst = 1'b1; fm_rsp_valid_in = 1'b1; fm_rsp_tq_id_in = 3'd3; step();
    chk("mid_rst_rv", 128'(fm2cache_rd_rsp_valid), 128'd0);
    step();
    fm2cache_req_ready = 1'b1;
    miss(28'h0000123, 3'd5); step();
    chk("post_rst_fo", 128'(fill_outstanding), 128'h20);
    step();

    // A clear and a set on the same id in one cycle: the set wins.
    miss(28'h0000055, 3'd5);
    fm_rsp_valid_in = 1'b1; fm_rsp_tq_id_in = 3'd5; fm_rsp_data_in = 128'h5; step();
    chk("set_wins", 128'(fill_outstanding[5]), 128'd1);
    miss(28'h0000066, 3'd5); step();
    chk("dup_flag", 128'(err_dup_fill), 128'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      fm2cache_req_ready = $urandom_range(0, 1);
      evict_valid_q3 = ($urandom_range(0, 9) < 3);
      evict_cl_address_q3 = 28'($urandom());
      evict_cl_data_q3 = {$urandom(), $urandom(), $urandom(), $urandom()};
      miss_valid_q3 = ($urandom_range(0, 9) < 4);
      miss_cl_address_q3 = 28'($urandom());
      miss_tq_id_q3 = 3'($urandom_range(0, 7));
      fm_rsp_valid_in = ($urandom_range(0, 9) < 4);
      fm_rsp_tq_id_in = 3'($urandom_range(0, 7));
      fm_rsp_data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_fm_req_q.md
CACHE_FM_REQ_Q -- requirements
Module: cache_fm_req_q

Interface
REQ-001 Parameter FM_Q_DEPTH, default 4: FM request queue entries, power of two, >= 2.
REQ-002 Parameter NUM_TQ_ENTRY, default 8: TQ entries; TQ_ID_W = log2(NUM_TQ_ENTRY) = 3.
REQ-003 Parameter CL_ADDR_W, default 28: cache-line address width (address[31:4]); cache line is 128 bits.
REQ-004 One clock and one reset: the design SHALL use a single clock, and reset SHALL be synchronous and active-high.
REQ-005 clk  in  1  clock, all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 miss_valid_q3  in  1  pipe q3 miss; a fill read is required.
REQ-008 miss_cl_address_q3  in  CL_ADDR_W  line to fetch.
REQ-009 miss_tq_id_q3  in  TQ_ID_W  owning TQ entry.
REQ-010 evict_valid_q3  in  1  pipe q3 dirty victim; a writeback is required.
REQ-011 evict_cl_address_q3  in  CL_ADDR_W  victim line address.
REQ-012 evict_cl_data_q3  in  128  victim line data.
REQ-013 fm_q_almost_full  out  1  high when free slots < 2; pipe/TQ stall.
REQ-014 cache2fm_req_valid  out  1  request present at queue head.
REQ-015 cache2fm_req_opcode  out  1  0 = FILL_RD, 1 = DIRTY_WB.
REQ-016 cache2fm_req_address / cache2fm_req_data / cache2fm_req_tq_id  out  CL_ADDR_W / 128 / TQ_ID_W  head entry fields; data is 0 for FILL_RD, tq_id is 0 for DIRTY_WB.
REQ-017 fm2cache_req_ready  in  1  FM accepts the head this cycle.
REQ-018 fm_rsp_valid_in / fm_rsp_data_in / fm_rsp_tq_id_in  in  1 / 128 / TQ_ID_W  FM fill read response.
REQ-019 fm2cache_rd_rsp_valid / _data / _tq_id  out  1 / 128 / TQ_ID_W  registered fill response to TQ.
REQ-020 fill_outstanding  out  NUM_TQ_ENTRY  per-TQ-id fill-in-flight vector.
REQ-021 err_overflow / err_dup_fill / err_bad_rsp  out  1 each  sticky error flags.

Function
REQ-022 The queue SHALL be a circular FIFO of FM_Q_DEPTH entries {opcode, address, data, tq_id} with wrapping read/write pointers and an occupancy count of width log2(FM_Q_DEPTH)+1.
REQ-023 When evict_valid_q3 and miss_valid_q3 are both high, the block SHALL push DIRTY_WB first and FILL_RD second in the same cycle (2 pushes); a single valid SHALL cause 1 push.
REQ-024 A head pop SHALL occur when cache2fm_req_valid && fm2cache_req_ready; push and pop in the same cycle SHALL both take effect, and count SHALL be updated by pushes minus pops.
REQ-025 cache2fm_req_valid SHALL equal (count != 0), and head fields SHALL be driven from storage (no input-to-output combinational path).
REQ-026 Head fields SHALL remain stable while valid && !ready.
REQ-027 fm_q_almost_full SHALL equal (FM_Q_DEPTH - count < 2), computed from registered count.
REQ-028 Any push that would exceed FM_Q_DEPTH (after counting the same-cycle pop) SHALL be dropped in full (no partial dual push) and SHALL set err_overflow.
REQ-029 A FILL_RD push SHALL set fill_outstanding[tq_id]; if that bit is already set, err_dup_fill SHALL be set and the entry still pushed.
REQ-030 fm_rsp_valid_in SHALL register into fm2cache_rd_rsp_* with a latency of exactly 1 cycle and SHALL clear fill_outstanding[fm_rsp_tq_id_in] on that edge.
REQ-031 A response whose tq_id bit is clear SHALL set err_bad_rsp, and fm2cache_rd_rsp_valid SHALL stay 0 for it.
REQ-032 When a response clears and a new fill sets the same tq_id in one cycle, the set SHALL win.
REQ-033 The error flags SHALL clear only on rst.

Reset
REQ-034 On rst the block SHALL force pointers, count, fill_outstanding, all error flags, cache2fm_req_valid and fm2cache_rd_rsp_valid to 0, and fm_q_almost_full to 0; FIFO data is don't-care.
REQ-035 A rst asserted mid-operation SHALL discard all queued and in-flight state on the next edge, with no output pulse after it.

Verification
REQ-036 Single miss with addr 0x0000123, tq_id 5, ready=1 -> next cycle req_valid=1, FILL_RD 0x0000123, tq 5, fill_outstanding=8'h20; popped the following cycle.
REQ-037 Dual push, evict 0x00000AA data 0xDEAD..., with miss 0x00000BB tq 2 and ready=0 -> count=2, almost_full=1 for depth 4 is false (2 free) becomes true after one more push; head order WB then FILL.
REQ-038 Fill queue to 4 with ready=0, then push -> err_overflow=1, count stays 4, head unchanged.
REQ-039 fm_rsp_valid_in with tq 2 and data 0x1111_2222_3333_4444 while bit 2 set -> one cycle later rd_rsp_valid=1 with same data; bit 2 cleared.
REQ-040 Response with tq 7 not outstanding -> err_bad_rsp=1, rd_rsp_valid stays 0.
REQ-041 rst asserted with 3 queued entries and 2 outstanding fills -> next cycle all outputs 0, then a new miss behaves as in REQ-036.
